exec_mult: RTL and testbench

EXEC_MULT -- requirements
Module: exec_mult

---
 rtl/exec_mult.sv | 179 +++++++++++++++++
 tb/tb_exec_mult.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mult.sv
// exec_mult: four-stage pipelined 32x32 multiplier feeding the common data bus.
//
// S1 holds the accepted operands, S2 holds the full 64-bit product, S3 carries
// the product one more stage, and S4 holds the selected 32-bit half and drives
// the cdb_* outputs straight from registers. Each stage has its own valid bit;
// a stage moves forward whenever the stage ahead of it is empty or is itself
// moving, so bubbles collapse even while the bus is not granting.
//
// Build option: define EXEC_MULT_SIGNED_EN to honour issue_signed (MULT vs
// MULTU). Without it every multiply is unsigned and issue_signed is ignored.
module exec_mult (
  input  logic        clk,
  input  logic        rst,
  // Issue side
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] issue_rsdata,
  input  logic [31:0] issue_rtdata,
  input  logic [5:0]  issue_tag,
  input  logic        issue_signed,
  input  logic        issue_hi,
  // Result bus side
  input  logic        cdb_grant,
  output logic        cdb_valid,
  output logic [31:0] cdb_data,
  output logic [5:0]  cdb_tag,
  output logic        cdb_branch,
  output logic        cdb_branch_taken
);

  // Signedness actually used for the multiply.
  logic signed_in;

`ifdef EXEC_MULT_SIGNED_EN
  assign signed_in = issue_signed;
`else
  assign signed_in = 1'b0;
  logic unused_issue_signed;
  assign unused_issue_signed = issue_signed;
`endif

  // Stage 1: operands
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_a_q;
  logic [31:0] s1_b_q;
  logic [5:0]  s1_tag_q;
  logic        s1_hi_q;
  logic        s1_signed_q;

  // Stage 2: full product
  logic        s2_valid_q, s2_valid_d;
  logic [63:0] s2_prod_q;
  logic [5:0]  s2_tag_q;
  logic        s2_hi_q;

  // Stage 3: full product, one more stage
  logic        s3_valid_q, s3_valid_d;
  logic [63:0] s3_prod_q;
  logic [5:0]  s3_tag_q;
  logic        s3_hi_q;

  // Stage 4: selected half, drives the bus
  logic        s4_valid_q, s4_valid_d;
  logic [31:0] s4_data_q;
  logic [5:0]  s4_tag_q;

  // Handshake / movement terms
  logic s1_adv, s2_adv, s3_adv, s4_adv;
  logic accept;

  // Multiplier datapath
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] mul_prod;
  logic [31:0] s3_half;

  // Stage advance chain: a stage moves when the next one is empty or moving.
  always_comb begin
    s4_adv = s4_valid_q & cdb_grant;
    s3_adv = s3_valid_q & (~s4_valid_q | s4_adv);
    s2_adv = s2_valid_q & (~s3_valid_q | s3_adv);
    s1_adv = s1_valid_q & (~s2_valid_q | s2_adv);
    issue_ready = ~s1_valid_q | s1_adv;
    accept = issue_valid & issue_ready;
  end

  // Next-state of the per-stage valid bits.
  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s1_adv);
    s2_valid_d = s1_adv | (s2_valid_q & ~s2_adv);
    s3_valid_d = s2_adv | (s3_valid_q & ~s3_adv);
    s4_valid_d = s3_adv | (s4_valid_q & ~s4_adv);
  end

  // 64x64 multiply of sign- or zero-extended operands; the low 64 bits are the
  // exact 32x32 product for both signed and unsigned operands.
  always_comb begin
    mul_a_ext = {{32{s1_signed_q & s1_a_q[31]}}, s1_a_q};
    mul_b_ext = {{32{s1_signed_q & s1_b_q[31]}}, s1_b_q};
    mul_prod  = mul_a_ext * mul_b_ext;
    s3_half   = s3_hi_q ? s3_prod_q[63:32] : s3_prod_q[31:0];
  end

  // Valid bits; reset discards everything in flight, including a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s4_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      s4_valid_q <= s4_valid_d;
    end
  end

  // S1 payload: captured on accept, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s1_hi_q     <= 1'b0;
      s1_signed_q <= 1'b0;
    end else if (accept) begin
      s1_a_q      <= issue_rsdata;
      s1_b_q      <= issue_rtdata;
      s1_tag_q    <= issue_tag;
      s1_hi_q     <= issue_hi;
      s1_signed_q <= signed_in;
    end
  end

  // S2 payload: product formed from S1 operands as the op moves forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_prod_q <= '0;
      s2_tag_q  <= '0;
      s2_hi_q   <= 1'b0;
    end else if (s1_adv) begin
      s2_prod_q <= mul_prod;
      s2_tag_q  <= s1_tag_q;
      s2_hi_q   <= s1_hi_q;
    end
  end

  // S3 payload: straight copy of S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_prod_q <= '0;
      s3_tag_q  <= '0;
      s3_hi_q   <= 1'b0;
    end else if (s2_adv) begin
      s3_prod_q <= s2_prod_q;
      s3_tag_q  <= s2_tag_q;
      s3_hi_q   <= s2_hi_q;
    end
  end

  // S4 payload: half selection; held steady while waiting for a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      s4_data_q <= '0;
      s4_tag_q  <= '0;
    end else if (s3_adv) begin
      s4_data_q <= s3_half;
      s4_tag_q  <= s3_tag_q;
    end
  end

  assign cdb_valid        = s4_valid_q;
  assign cdb_data         = s4_data_q;
  assign cdb_tag          = s4_tag_q;
  assign cdb_branch       = 1'b0;
  assign cdb_branch_taken = 1'b0;

endmodule

// File: tb/tb_exec_mult.sv
// Self-checking bench for exec_mult: directed cases with literal expectations
// plus randomized traffic compared every cycle against an in-order queue model.
module tb_exec_mult;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_rsdata;
  logic [31:0] issue_rtdata;
  logic [5:0]  issue_tag;
  logic        issue_signed;
  logic        issue_hi;
  logic        cdb_grant;
  logic        cdb_valid;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_tag;
  logic        cdb_branch;
  logic        cdb_branch_taken;

  exec_mult dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_rsdata     (issue_rsdata),
    .issue_rtdata     (issue_rtdata),
    .issue_tag        (issue_tag),
    .issue_signed     (issue_signed),
    .issue_hi         (issue_hi),
    .cdb_grant        (cdb_grant),
    .cdb_valid        (cdb_valid),
    .cdb_data         (cdb_data),
    .cdb_tag          (cdb_tag),
    .cdb_branch       (cdb_branch),
    .cdb_branch_taken (cdb_branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: full 64-bit product, then pick the requested half.
  function automatic logic [31:0] ref_half(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn, input logic hi);
    logic [63:0] p;
    logic        use_signed;
    longint      sa;
    longint      sb;
`ifdef EXEC_MULT_SIGNED_EN
    use_signed = sgn;
`else
    use_signed = 1'b0;
`endif
    if (use_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    return hi ? p[63:32] : p[31:0];
  endfunction

  // Model: results leave in acceptance order, each no sooner than 3 edges after
  // its accept edge; the pipe holds at most 4 ops.
  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
    int          acc_edge;
  } op_t;

  op_t         q[$];
  logic [5:0]  pop_log[$];
  int          edge_n = 0;
  bit          known  = 0;

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    op_t  o;
    exp_valid = (q.size() > 0) && (q[0].acc_edge + 3 <= edge_n);
    exp_ready = (q.size() < 4) || (exp_valid && cdb_grant);
    if (known) begin
      check("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
      check("issue_ready", 64'(issue_ready), 64'(exp_ready));
      check("cdb_branch", 64'({cdb_branch, cdb_branch_taken}), 64'(0));
      if (exp_valid && cdb_valid) begin
        check("cdb_tag", 64'(cdb_tag), 64'(q[0].tag));
        check("cdb_data", 64'(cdb_data), 64'(q[0].data));
      end
    end
    edge_n++;
    if (rst) begin
      q.delete();
      known = 1;
    end else if (known) begin
      if (exp_valid && cdb_grant) begin
        pop_log.push_back(cdb_tag);
        void'(q.pop_front());
      end
      if (issue_valid && issue_ready) begin
        o.tag      = issue_tag;
        o.data     = ref_half(issue_rsdata, issue_rtdata, issue_signed, issue_hi);
        o.acc_edge = edge_n;
        q.push_back(o);
      end
    end
  end

  // Present one op until accepted (bounded), then drop issue_valid.
  task automatic issue_one(input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                           input logic hi, input logic sgn);
    bit acc;
    issue_valid  = 1'b1;
    issue_rsdata = a;
    issue_rtdata = b;
    issue_tag    = tag;
    issue_hi     = hi;
    issue_signed = sgn;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = issue_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("issue_one_accept_timeout", 64'(0), 64'(1));
    issue_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && !cdb_valid;
    end
    check(name, 64'(done), 64'(1));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ops;
    int cyc;
    int next_tag;
    int got;
    bit acc;
    logic [31:0] exp29;

    rst = 1'b1;
    issue_valid = 1'b0;
    issue_rsdata = '0;
    issue_rtdata = '0;
    issue_tag = '0;
    issue_signed = 1'b0;
    issue_hi = 1'b0;
    cdb_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset_cdb_valid", 64'(cdb_valid), 64'(0));
    check("reset_cdb_data", 64'(cdb_data), 64'(0));
    check("reset_cdb_tag", 64'(cdb_tag), 64'(0));
    check("reset_issue_ready", 64'(issue_ready), 64'(1));

    // 3*5, tag 7, grant held: valid exactly one cycle, 3 edges after accept
    cdb_grant = 1'b1;
    issue_one(32'd3, 32'd5, 6'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("lat_s2_not_valid", 64'(cdb_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_s3_not_valid", 64'(cdb_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_valid", 64'(cdb_valid), 64'(1));
    check("lat_data", 64'(cdb_data), 64'h0000_000F);
    check("lat_tag", 64'(cdb_tag), 64'(7));
    @(posedge clk); #1;
    check("lat_one_cycle", 64'(cdb_valid), 64'(0));

    // 0xFFFFFFFF * 2, high half, signed request
`ifdef EXEC_MULT_SIGNED_EN
    exp29 = 32'hFFFF_FFFF;
`else
    exp29 = 32'h0000_0001;
`endif
    issue_one(32'hFFFF_FFFF, 32'd2, 6'd9, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("hi_signed_data", 64'(cdb_data), 64'(exp29));
    issue_one(32'hFFFF_FFFF, 32'd2, 6'd10, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("lo_signed_data", 64'(cdb_data), 64'hFFFF_FFFE);
    wait_drain("drain_directed");

    // Stall with grant low: tags 1..6 offered, exactly 4 fit
    pop_log.delete();
    cdb_grant = 1'b0;
    next_tag = 1;
    issue_valid = 1'b1;
    issue_tag = 6'(next_tag);
    issue_rsdata = 32'h1234_5678;
    issue_rtdata = 32'h0000_0010;
    issue_hi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = issue_valid && issue_ready;
      @(posedge clk);
      #1;
      if (acc) next_tag++;
      issue_tag = 6'(next_tag);
    end
    check("stall_accepted", 64'(next_tag - 1), 64'(4));
    check("stall_ready_low", 64'(issue_ready), 64'(0));
    check("stall_out_tag", 64'(cdb_tag), 64'(1));
    cdb_grant = 1'b1;
    for (int i = 0; i < 20 && next_tag <= 6; i++) begin
      @(negedge clk);
      acc = issue_valid && issue_ready;
      @(posedge clk);
      #1;
      if (acc) next_tag++;
      issue_tag = 6'(next_tag);
      if (next_tag > 6) issue_valid = 1'b0;
    end
    issue_valid = 1'b0;
    wait_drain("drain_stall");
    check("stall_pop_count", 64'(pop_log.size()), 64'(6));
    for (int i = 0; i < pop_log.size() && i < 6; i++)
      check("stall_pop_order", 64'(pop_log[i]), 64'(i + 1));

    // Reset with 3 ops in flight and an accept pending
    cdb_grant = 1'b0;
    got = 0;
    issue_valid = 1'b1;
    for (int i = 0; i < 10 && got < 3; i++) begin
      issue_tag = 6'(20 + got);
      @(negedge clk);
      acc = issue_ready;
      @(posedge clk);
      #1;
      if (acc) got++;
    end
    issue_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    issue_valid = 1'b1;
    issue_tag = 6'd33;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue_valid = 1'b0;
    check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    check("rst_issue_ready", 64'(issue_ready), 64'(1));
    cdb_grant = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Random traffic: 1000 ops, random valid and grant
    ops = 0;
    cyc = 0;
    while (ops < 1000 && cyc < 20000) begin
      issue_valid  = ($urandom_range(0, 9) < 7);
      cdb_grant    = ($urandom_range(0, 9) < 6);
      issue_rsdata = rand_operand();
      issue_rtdata = rand_operand();
      issue_signed = $urandom_range(0, 1);
      issue_hi     = $urandom_range(0, 1);
      issue_tag    = 6'(ops);
      @(negedge clk);
      if (issue_valid && issue_ready) ops++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("random_ops_accepted", 64'(ops), 64'(1000));
    issue_valid = 1'b0;
    cdb_grant = 1'b1;
    wait_drain("drain_random");
    check("model_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
